// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the shared ALU arbiter.
// Master modport for the requesters, slave modport for the arbiter.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0;
   logic             req1;
   logic [2:0]       ctrl0;
   logic [2:0]       ctrl1;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic             gnt0;
   logic             gnt1;
   logic             done0;
   logic             done1;
   logic [WIDTH-1:0] res;
   logic             res_z;
   logic             res_abcd;
   logic             busy;

   modport master (
      output req0, req1, ctrl0, ctrl1,
      output a0, b0, a1, b1,
      input  gnt0, gnt1, done0, done1,
      input  res, res_z, res_abcd, busy
   );

   modport slave (
      input  req0, req1, ctrl0, ctrl1,
      input  a0, b0, a1, b1,
      output gnt0, gnt1, done0, done1,
      output res, res_z, res_abcd, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Round-robin by default; ALU_ARB_FIXED_PRIO_EN selects fixed priority.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_if.slave     bus,
   output logic [2:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_z,
   input  logic             alu_abcd
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             z_q, z_d;
   logic             abcd_q, abcd_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic             busy_q, busy_d;
   logic             pick1;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Requester 0 always wins a contested cycle
   always_comb pick1 = ~bus.req0;
`else
   logic last_q, last_d;

   // Contested cycle goes to whoever was not served last
   always_comb pick1 = bus.req1 & (~bus.req0 | ~last_q);

   // Remember the most recently granted requester
   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && (bus.req0 || bus.req1))
         last_d = pick1;
   end

   // Round-robin pointer; requester 0 wins first after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
   end
`endif

   // Next state, operand capture and registered output pulses
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ctrl_d  = ctrl_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      z_d     = z_q;
      abcd_d  = abcd_q;
      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               state_d = EXEC;
               owner_d = pick1;
               ctrl_d  = pick1 ? bus.ctrl1 : bus.ctrl0;
               a_d     = pick1 ? bus.a1 : bus.a0;
               b_d     = pick1 ? bus.b1 : bus.b0;
            end
         end
         EXEC: begin
            state_d = RESP;
            res_d   = alu_out;
            z_d     = alu_z;
            abcd_d  = alu_abcd;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      gnt0_d  = (state_d == EXEC) & ~owner_d;
      gnt1_d  = (state_d == EXEC) &  owner_d;
      done0_d = (state_d == RESP) & ~owner_d;
      done1_d = (state_d == RESP) &  owner_d;
      busy_d  = (state_d != IDLE);
   end

   // State and datapath registers; reset drops any in-flight op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         ctrl_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         z_q     <= 1'b0;
         abcd_q  <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ctrl_q  <= ctrl_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         z_q     <= z_d;
         abcd_q  <= abcd_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
      end
   end

   assign alu_ctrl     = ctrl_q;
   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign bus.gnt0     = gnt0_q;
   assign bus.gnt1     = gnt1_q;
   assign bus.done0    = done0_q;
   assign bus.done1    = done1_q;
   assign bus.res      = res_q;
   assign bus.res_z    = z_q;
   assign bus.res_abcd = abcd_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU.
// Honours ALU_ARB_FIXED_PRIO_EN for the contention order.
module tb_alu_arbiter;
   logic        clk;
   logic        rst_n;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_out;
   logic        alu_z;
   logic        alu_abcd;
   int          checks;
   int          errors;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .alu_ctrl (alu_ctrl),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_out  (alu_out),
      .alu_z    (alu_z),
      .alu_abcd (alu_abcd)
   );

   always #5 clk = ~clk;

   // Shared combinational ALU
   always_comb begin
      alu_out = '0;
      case (alu_ctrl)
         3'b000:  alu_out = alu_a + alu_b;
         3'b001:  alu_out = alu_a - alu_b;
         3'b010:  alu_out = alu_a & alu_b;
         3'b011:  alu_out = alu_a | alu_b;
         3'b100:  alu_out = alu_a ^ alu_b;
         3'b101:  alu_out = alu_a << alu_b[4:0];
         3'b110:  alu_out = $signed(alu_a) >>> alu_b[4:0];
         default: alu_out = alu_a + alu_b;
      endcase
   end
   assign alu_z    = (alu_out == 32'h0);
   assign alu_abcd = (alu_out == 32'h0000_ABCD);

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_op(input bit who, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er,
                         input bit ez, input bit ea);
      if (who) begin
         bus.req1 = 1'b1; bus.ctrl1 = c; bus.a1 = a; bus.b1 = b;
      end else begin
         bus.req0 = 1'b1; bus.ctrl0 = c; bus.a0 = a; bus.b0 = b;
      end
      @(negedge clk);
      chk("op_gnt0", {31'b0, bus.gnt0}, {31'b0, !who});
      chk("op_gnt1", {31'b0, bus.gnt1}, {31'b0, who});
      chk("op_ctrl", {29'b0, alu_ctrl}, {29'b0, c});
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      chk("op_done", {31'b0, who ? bus.done1 : bus.done0}, 32'd1);
      chk("op_res", bus.res, er);
      chk("op_z", {31'b0, bus.res_z}, {31'b0, ez});
      chk("op_abcd", {31'b0, bus.res_abcd}, {31'b0, ea});
      @(negedge clk);
      chk("op_idle", {31'b0, bus.busy}, 32'd0);
   endtask

   initial begin
      logic [3:0]  seq;
      logic [3:0]  exp_seq;
      int          ngnt;
      int          ndone;
      clk = 1'b0;
      rst_n = 1'b0;
      checks = 0;
      errors = 0;
      bus.req0 = 1'b1; bus.ctrl0 = 3'b000;
      bus.a0 = 32'd1;  bus.b0 = 32'd2;
      bus.req1 = 1'b0; bus.ctrl1 = 3'b000;
      bus.a1 = 32'd0;  bus.b1 = 32'd0;

      // reset with req0 held
      repeat (3) @(negedge clk);
      chk("rst_flags", {26'b0, bus.gnt0, bus.gnt1, bus.done0,
                        bus.done1, bus.busy, bus.res_z}, 32'd0);
      chk("rst_res", bus.res, 32'd0);
      chk("rst_alu", {29'b0, alu_ctrl} | alu_a | alu_b, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_gnt0", {31'b0, bus.gnt0}, 32'd1);
      chk("rel_busy", {31'b0, bus.busy}, 32'd1);
      bus.req0 = 1'b0;
      @(negedge clk);
      chk("rel_done0", {31'b0, bus.done0}, 32'd1);
      chk("rel_res", bus.res, 32'd3);
      @(negedge clk);
      chk("rel_quiet", {29'b0, bus.done0, bus.gnt0, bus.busy}, 32'd0);

      // single ops and flags
      run_op(1'b0, 3'b001, 32'd10, 32'd10, 32'd0, 1'b1, 1'b0);
      run_op(1'b1, 3'b000, 32'h0000_AB00, 32'h0000_00CD,
             32'h0000_ABCD, 1'b0, 1'b1);
      run_op(1'b0, 3'b010, 32'h0000_F0F0, 32'h0000_FF00,
             32'h0000_F000, 1'b0, 1'b0);
      run_op(1'b1, 3'b011, 32'h1200_0000, 32'h0000_0034,
             32'h1200_0034, 1'b0, 1'b0);
      run_op(1'b0, 3'b100, 32'h0000_FFFF, 32'h0000_FFFF,
             32'h0, 1'b1, 1'b0);
      run_op(1'b0, 3'b101, 32'd1, 32'd4, 32'd16, 1'b0, 1'b0);
      run_op(1'b1, 3'b111, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0);

      // contention: last served was 1
      bus.req0 = 1'b1; bus.ctrl0 = 3'b110;
      bus.a0 = 32'hFFFF_FFF8; bus.b0 = 32'd1;
      bus.req1 = 1'b1; bus.ctrl1 = 3'b110;
      bus.a1 = 32'hFFFF_FFF8; bus.b1 = 32'd1;
      seq = '0;
      ngnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.gnt0 || bus.gnt1) begin
            seq = {seq[2:0], bus.gnt1};
            ngnt++;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_seq = 4'b0000;
`else
      exp_seq = 4'b0101;
`endif
      chk("cont_ngnt", ngnt, 32'd4);
      chk("cont_order", {28'b0, seq}, {28'b0, exp_seq});
      chk("cont_sra", bus.res, 32'hFFFF_FFFC);
      @(negedge clk);

      // mid-op reset
      bus.req0 = 1'b1; bus.ctrl0 = 3'b000;
      bus.a0 = 32'd7; bus.b0 = 32'd8;
      @(negedge clk);
      chk("mid_gnt0", {31'b0, bus.gnt0}, 32'd1);
      bus.req0 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst", {29'b0, bus.gnt0, bus.busy, bus.done0}, 32'd0);
      chk("mid_res", bus.res, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.done0 || bus.done1) ndone++;
      end
      chk("mid_nodone", ndone, 32'd0);
      chk("mid_res_hold", bus.res, 32'd0);
      bus.req0 = 1'b1; bus.ctrl0 = 3'b000;
      bus.a0 = 32'd1; bus.b0 = 32'd1;
      bus.req1 = 1'b1; bus.ctrl1 = 3'b000;
      bus.a1 = 32'd2; bus.b1 = 32'd2;
      @(negedge clk);
      chk("mid_first", {30'b0, bus.gnt1, bus.gnt0}, 32'd1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      chk("mid_res2", bus.res, 32'd2);
      @(negedge clk);

      // req0 held across a full transaction
      bus.req0 = 1'b1; bus.ctrl0 = 3'b000;
      bus.a0 = 32'd100; bus.b0 = 32'd1;
      @(negedge clk);
      chk("hold_gnt_a", {31'b0, bus.gnt0}, 32'd1);
      bus.a0 = 32'd200;
      @(negedge clk);
      chk("hold_res_a", bus.res, 32'd101);
      @(negedge clk);
      chk("hold_idle", {30'b0, bus.gnt0, bus.res == 32'd101}, 32'd1);
      @(negedge clk);
      chk("hold_gnt_b", {31'b0, bus.gnt0}, 32'd1);
      chk("hold_exec_res", bus.res, 32'd101);
      bus.req0 = 1'b0;
      @(negedge clk);
      chk("hold_res_b", bus.res, 32'd201);
      chk("hold_done_b", {31'b0, bus.done0}, 32'd1);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU between two requesters (e.g. the pipeline control unit and a debug/DMA agent). Round-robin arbitration, operand capture, registered result and flag return. Sits in front of the ALU: drives its control and operand inputs and samples its Output, Z and ABCD outputs. Fixed 3-cycle transaction, one operation in flight at a time.

## Interface
- WIDTH, 32, operand/result width; must equal the ALU width (32).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  operation request, requester 0 / 1.
- ctrl0 / ctrl1  in  3  ALU control code (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 sra, 111 add).
- a0, b0 / a1, b1  in  WIDTH  operands.
- gnt0 / gnt1  out  1  one-cycle grant pulse; operands have been captured.
- done0 / done1  out  1  one-cycle result-valid pulse.
- res  out  WIDTH  registered result, shared by both requesters.
- res_z  out  1  registered Z flag (result == 0).
- res_abcd  out  1  registered ABCD flag (result == 0x0000ABCD).
- busy  out  1  high in EXEC and RESP.
- alu_ctrl  out  3  to ALU control.
- alu_a, alu_b  out  WIDTH  to ALU operands.
- alu_out  in  WIDTH  from ALU Output.
- alu_z, alu_abcd  in  1  from ALU flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if neither req high, stay. Otherwise select winner, latch its ctrl/a/b into alu_ctrl/alu_a/alu_b, record owner, go to EXEC.
- Round-robin: pointer `last` holds the last-served requester. One request → grant it. Both → grant the requester != last. `last` is updated on the IDLE→EXEC transition.
- EXEC: ALU inputs stable from registers. At the end of the cycle, capture alu_out, alu_z and alu_abcd into res, res_z and res_abcd. Go to RESP.
- RESP: assert done of the owner. Go to IDLE.
- gnt of the owner is high for exactly the EXEC cycle. done of the owner is high for exactly the RESP cycle. The non-owner's gnt/done stay 0.
- res/res_z/res_abcd hold their value until the next EXEC capture.
- req is sampled only in IDLE. A requester must drop req in the cycle it sees gnt. If req is still high when the FSM re-enters IDLE, it is a new request.
- ctrl 111 is passed through unchanged. The ALU treats it as add.
- Reset (async, any state):
  - state=IDLE, last=1 (requester 0 wins the first contested arbitration).
  - gnt0, gnt1, done0, done1, busy, res, res_z, res_abcd, alu_ctrl, alu_a, alu_b all 0.
  - An in-flight operation is discarded; no done is produced after reset release.

## Timing
- Latency, req high in IDLE at edge N:
  - gnt in cycle N+1 (EXEC).
  - done and res valid in cycle N+2 (RESP).
- Throughput: one operation per 3 cycles. With both requesters permanently requesting, grants alternate 0,1,0,1…
- Combinational path: alu_a/alu_b/alu_ctrl registers → ALU → res capture, within one clock period.
- No combinational path from any input to any output.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority. Requester 0 always wins a contested IDLE cycle, `last` is unused, and requester 1 may starve.
- Not defined (default): round-robin as described above.

## Test plan
- Reset: hold rst_n=0 with req0=1 → all outputs 0. Release → gnt0 at +1 cycle, done0 at +2.
- Single op: req0, ctrl0=001, a0=10, b0=10 → gnt0 pulse, then done0 with res=0, res_z=1, res_abcd=0.
- ABCD flag: req1, ctrl1=000, a1=0x0000AB00, b1=0x000000CD → done1 with res=0x0000ABCD, res_abcd=1, res_z=0.
- Contention: req0 and req1 held high for 12 cycles → grant order 0,1,0,1; sra with a=-8, b=1 returns res=-4 (0xFFFFFFFC). With `ALU_ARB_FIXED_PRIO_EN` defined → grant order 0,0,0,0.
- Mid-op reset: assert rst_n=0 during EXEC → no done, res=0. First contested request after release goes to requester 0.
- Request hold rule: req0 held high across a full transaction → second grant to requester 0 in the next IDLE cycle; res is updated only in EXEC.
